memory_sequence_ctrl: RTL and testbench

Sequencer that owns the 16x4 synchronous game RAM (registered address, read data valid one cycle after the address is presented) for the Memory Challenge game. Accepts three commands from the game FSM: play back the stored sequence, check player moves against it, append a new move. Drives every RAM port. Sequence length, playback timing and the compare result stay inside this block, so the top-level FSM only issues commands and waits for the completion pulses.

---
 rtl/memory_sequence_ctrl_pkg.sv | 24 ++
 rtl/memory_sequence_ctrl_timer_down.sv | 22 ++
 rtl/memory_sequence_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_memory_sequence_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_sequence_ctrl_pkg.sv
// Shared types and constants for the Memory Challenge sequencer.
package memory_sequence_ctrl_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned LEN_W  = 5;

  typedef enum logic [2:0] {
    IDLE, P_ADDR, P_SHOW, P_GAP, C_WAIT, C_CMP, A_WR
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ram_req_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memory_sequence_ctrl_timer_down.sv
// Loadable down-counter that parks at zero; times the show and gap intervals.
module memory_sequence_ctrl_timer_down #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - W'(1);
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/memory_sequence_ctrl.sv
// Owns the game RAM: plays the stored sequence, checks player moves, appends moves.
module memory_sequence_ctrl
  import memory_sequence_ctrl_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned INIT_LEN    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_play,
  input  logic              cmd_check,
  input  logic              cmd_append,
  input  logic [DATA_W-1:0] append_data,
  input  logic [DATA_W-1:0] jogada,
  input  logic              jogada_valid,
  input  logic              abort,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic [DATA_W-1:0] led_value,
  output logic              show_valid,
  output logic              play_done,
  output logic              round_ok,
  output logic              wrong,
  output logic              err_full,
  output logic              full,
  output logic [LEN_W-1:0]  seq_len,
  output logic [ADDR_W-1:0] idx
);

  localparam int unsigned CNT_W =
    cnt_width((SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES);
  localparam logic [LEN_W-1:0] LEN_RST  = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

  state_t            state, state_n;
  ram_req_t          ram_r, ram_n;
  logic [ADDR_W-1:0] idx_n;
  logic [LEN_W-1:0]  seq_len_n;
  logic [DATA_W-1:0] led_n, jog;
  logic              show_n, play_done_n, round_ok_n, wrong_n, err_full_n;
  logic              jog_load, tmr_load, tmr_zero, last;
  logic [CNT_W-1:0]  tmr_val;

  assign last = ({1'b0, idx} == seq_len - LEN_W'(1));

  memory_sequence_ctrl_timer_down #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_c   (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      seq_len    <= LEN_RST;
      full       <= (LEN_RST == LEN_FULL);
      ram_r      <= '0;
      led_value  <= '0;
      show_valid <= 1'b0;
      play_done  <= 1'b0;
      round_ok   <= 1'b0;
      wrong      <= 1'b0;
      err_full   <= 1'b0;
      busy       <= 1'b0;
      jog        <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      seq_len    <= seq_len_n;
      full       <= (seq_len_n == LEN_FULL);
      ram_r      <= ram_n;
      led_value  <= led_n;
      show_valid <= show_n;
      play_done  <= play_done_n;
      round_ok   <= round_ok_n;
      wrong      <= wrong_n;
      err_full   <= err_full_n;
      busy       <= (state_n != IDLE);
      if (jog_load) jog <= jogada;
    end
  end

  assign ram_addr = ram_r.addr;
  assign ram_we   = ram_r.we;
  assign ram_data = ram_r.data;

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    seq_len_n   = seq_len;
    play_done_n = 1'b0;
    round_ok_n  = 1'b0;
    wrong_n     = 1'b0;
    err_full_n  = 1'b0;
    jog_load    = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    ram_n       = ram_r;

    case (state)
      IDLE: begin
        if (cmd_play) begin
          idx_n = '0;
          if (seq_len == '0) play_done_n = 1'b1;
          else               state_n = P_ADDR;
        end else if (cmd_check) begin
          idx_n = '0;
          if (seq_len == '0) round_ok_n = 1'b1;
          else               state_n = C_WAIT;
        end else if (cmd_append) begin
          idx_n = '0;
          if (seq_len == LEN_FULL) begin
            err_full_n = 1'b1;
          end else begin
            state_n    = A_WR;
            ram_n.data = append_data;
          end
        end
      end
      P_ADDR: begin
        state_n  = P_SHOW;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(SHOW_CYCLES - 1);
      end
      P_SHOW: begin
        if (tmr_zero) begin
          state_n  = P_GAP;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(GAP_CYCLES - 1);
        end
      end
      P_GAP: begin
        if (tmr_zero) begin
          if (last) begin
            play_done_n = 1'b1;
            state_n     = IDLE;
          end else begin
            idx_n   = idx + ADDR_W'(1);
            state_n = P_ADDR;
          end
        end
      end
      C_WAIT: begin
        if (jogada_valid) begin
          jog_load = 1'b1;
          state_n  = C_CMP;
        end
      end
      C_CMP: begin
        if (jog != ram_q) begin
          wrong_n = 1'b1;
          state_n = IDLE;
        end else if (last) begin
          round_ok_n = 1'b1;
          state_n    = IDLE;
        end else begin
          idx_n   = idx + ADDR_W'(1);
          state_n = C_WAIT;
        end
      end
      A_WR: begin
        seq_len_n = (seq_len == LEN_FULL) ? seq_len : seq_len + LEN_W'(1);
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Abort wins over everything except the length update of a write already on the bus.
    if (abort) begin
      state_n     = IDLE;
      idx_n       = '0;
      play_done_n = 1'b0;
      round_ok_n  = 1'b0;
      wrong_n     = 1'b0;
      err_full_n  = 1'b0;
    end

    // RAM data arrives a cycle after the address, so the display trails P_SHOW by one cycle.
    led_n  = (state == P_SHOW && !abort) ? ram_q : '0;
    show_n = (state == P_SHOW && !abort);

    ram_n.we   = (state_n == A_WR);
    ram_n.addr = ram_n.we ? seq_len[ADDR_W-1:0] : idx_n;
  end

endmodule

// File: tb/tb_memory_sequence_ctrl.sv
// Directed bench for memory_sequence_ctrl with a behavioural RAM and queued expectations.
module tb_memory_sequence_ctrl;

  localparam logic [3:0] P_PLAY = 4'b0001;
  localparam logic [3:0] P_OK   = 4'b0010;
  localparam logic [3:0] P_WR   = 4'b0100;
  localparam logic [3:0] P_ERRF = 4'b1000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_play, cmd_check, cmd_append, jogada_valid, abort;
  logic [3:0] append_data, jogada;
  logic [3:0] ram_addr, ram_data, ram_q, led_value, idx;
  logic       ram_we, busy, show_valid, play_done, round_ok, wrong, err_full, full;
  logic [4:0] seq_len;

  logic [3:0] mem     [16] = '{0: 4'h1, default: 4'h0};
  logic [3:0] exp_mem [16] = '{0: 4'h1, default: 4'h0};
  logic [3:0] raddr = '0;
  logic [3:0] led_q[$];
  logic [3:0] pulse_q[$];
  logic [3:0] pcode;
  logic       prev_show = 1'b0;
  int         errors = 0;
  int         checks = 0;
  int         exp_len = 1;
  int         busy_cnt, show_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    raddr <= ram_addr;
  end
  assign ram_q = mem[raddr];

  memory_sequence_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_play(cmd_play), .cmd_check(cmd_check), .cmd_append(cmd_append),
    .append_data(append_data), .jogada(jogada), .jogada_valid(jogada_valid),
    .abort(abort), .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data),
    .ram_q(ram_q), .busy(busy), .led_value(led_value), .show_valid(show_valid),
    .play_done(play_done), .round_ok(round_ok), .wrong(wrong), .err_full(err_full),
    .full(full), .seq_len(seq_len), .idx(idx)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pulses and shown entries are popped as the DUT produces them.
  always @(negedge clk) begin
    pcode = {err_full, wrong, round_ok, play_done};
    if (pcode != 4'b0000) begin
      if (pulse_q.size() == 0) chk("pulse_unexpected", int'(pcode), 0);
      else                     chk("pulse", int'(pcode), int'(pulse_q.pop_front()));
    end
    if (show_valid && !prev_show) begin
      if (led_q.size() == 0) chk("show_unexpected", int'(led_value), 0);
      else                   chk("led_value", int'(led_value), int'(led_q.pop_front()));
    end
    prev_show = show_valid;
  end

  task automatic do_append(input logic [3:0] v);
    cmd_append = 1'b1; append_data = v;
    @(negedge clk);
    cmd_append = 1'b0;
    chk("app_we", int'(ram_we), 1);
    chk("app_addr", int'(ram_addr), exp_len % 16);
    chk("app_data", int'(ram_data), int'(v));
    exp_mem[exp_len % 16] = v;
    @(negedge clk);
    exp_len++;
    chk("app_len", int'(seq_len), exp_len);
  endtask

  task automatic move(input logic [3:0] v);
    jogada = v; jogada_valid = 1'b1;
    @(negedge clk);
    jogada_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    reset_n = 1'b0; cmd_play = 1'b0; cmd_check = 1'b0; cmd_append = 1'b0;
    jogada_valid = 1'b0; abort = 1'b0; append_data = '0; jogada = '0;
    repeat (2) @(negedge clk);
    chk("rst_len", int'(seq_len), 1);
    chk("rst_idx", int'(idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_full", int'(full), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Playback of the preloaded single entry
    cmd_play = 1'b1; led_q.push_back(4'h1); pulse_q.push_back(P_PLAY);
    @(negedge clk);
    cmd_play = 1'b0;
    chk("t1_addr", int'(ram_addr), 0);
    chk("t1_busy", int'(busy), 1);
    busy_cnt = 0; show_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (play_done) break;
      busy_cnt += int'(busy); show_cnt += int'(show_valid);
      @(negedge clk);
    end
    chk("t1_busy_cycles", busy_cnt, 7);
    chk("t1_show_cycles", show_cnt, 4);
    chk("t1_done", int'(play_done), 1);
    chk("t1_done_idle", int'(busy), 0);

    // Append two moves, then replay all three
    do_append(4'h2);
    do_append(4'h4);
    chk("t2_mem1", int'(mem[1]), 2);
    chk("t2_mem2", int'(mem[2]), 4);
    cmd_play = 1'b1;
    for (int i = 0; i < exp_len; i++) led_q.push_back(exp_mem[i]);
    pulse_q.push_back(P_PLAY);
    @(negedge clk);
    cmd_play = 1'b0;
    wait_idle(60);

    // Check: full match, then mismatch on the second move
    cmd_check = 1'b1; pulse_q.push_back(P_OK);
    @(negedge clk);
    cmd_check = 1'b0;
    move(4'h1); move(4'h2); move(4'h4);
    chk("t3_ok_idle", int'(busy), 0);
    cmd_check = 1'b1; pulse_q.push_back(P_WR);
    @(negedge clk);
    cmd_check = 1'b0;
    move(4'h1); move(4'h8);
    chk("t3_wrong_idx", int'(idx), 1);
    chk("t3_wrong_idle", int'(busy), 0);

    // Play beats append in the same cycle; abort mid-show
    cmd_play = 1'b1; cmd_append = 1'b1; append_data = 4'h9;
    led_q.push_back(exp_mem[0]);
    @(negedge clk);
    cmd_play = 1'b0; cmd_append = 1'b0;
    chk("t5_no_we", int'(ram_we), 0);
    chk("t5_busy", int'(busy), 1);
    repeat (2) @(negedge clk);
    chk("t5_showing", int'(show_valid), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_idle", int'(busy), 0);
    chk("t5_abort_led", int'(led_value), 0);
    chk("t5_abort_idx", int'(idx), 0);
    chk("t5_len_kept", int'(seq_len), 3);
    repeat (10) @(negedge clk);
    chk("t5_mem3", int'(mem[3]), 0);

    // Fill to 16, then a rejected append
    while (exp_len < 16) do_append(4'(exp_len ^ 5));
    chk("t4_full", int'(full), 1);
    chk("t4_len", int'(seq_len), 16);
    cmd_append = 1'b1; append_data = 4'hF; pulse_q.push_back(P_ERRF);
    @(negedge clk);
    cmd_append = 1'b0;
    chk("t4_no_we", int'(ram_we), 0);
    chk("t4_stay_idle", int'(busy), 0);
    @(negedge clk);
    chk("t4_len_sat", int'(seq_len), 16);
    chk("t4_mem0", int'(mem[0]), 1);

    // Asynchronous reset while waiting for a move
    cmd_check = 1'b1;
    @(negedge clk);
    cmd_check = 1'b0;
    move(exp_mem[0]);
    chk("t6_pre_idx", int'(idx), 1);
    chk("t6_pre_busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_len", int'(seq_len), 1);
    chk("t6_idx", int'(idx), 0);
    chk("t6_full", int'(full), 0);
    chk("t6_addr", int'(ram_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("led_q_left", led_q.size(), 0);
    chk("pulse_q_left", pulse_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
